// File: rtl/input_capture.sv
// Input capture: measures period and high time of an asynchronous input in
// prescaled clock ticks, one result per rising-to-rising cycle.
module input_capture #(
  parameter int WIDTH       = 16,
  parameter int DIV         = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             signal_in,
  input  logic             clear_overflow,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  // state        | meaning
  // IDLE         | waiting for an enabled rising edge to start a measurement
  // MEASURE_HIGH | input high, timer running, waiting for the falling edge
  // MEASURE_LOW  | input low, timer running, waiting for the closing rising edge
  typedef enum logic [1:0] {IDLE, MEASURE_HIGH, MEASURE_LOW} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [WIDTH-1:0]       timer_q, timer_d;
  logic [WIDTH-1:0]       hi_latch_q, hi_latch_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic [WIDTH-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;

  logic             sync_in, rise, fall;
  logic             tick, sat, start_clr;
  logic [WIDTH-1:0] timer_next;

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_q;
  assign fall    = ~sync_in & prev_q;
  assign busy    = (state_q != IDLE);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], signal_in};
    prev_d = sync_in;
  end

  // Prescaler only exists when ticks are slower than the clock.
  if (DIV > 0) begin : g_pre
    localparam logic [DIV-1:0] PRE_ONE = DIV'(1);
    logic [DIV-1:0] pre_q, pre_d;

    always_comb begin
      pre_d = pre_q;
      if (start_clr)
        pre_d = '0;
      else if (busy)
        pre_d = pre_q + PRE_ONE;
    end

    always_ff @(posedge clk) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
    end

    assign tick = busy & (&pre_q);
  end else begin : g_nopre
    assign tick = busy;
  end

  assign sat        = tick & (&timer_q);
  assign timer_next = (tick && !(&timer_q)) ? timer_q + 1'b1 : timer_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    hi_latch_d = hi_latch_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q & ~clear_overflow;
    start_clr  = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            start_clr = 1'b1;
            state_d   = MEASURE_HIGH;
          end
        end
        MEASURE_HIGH: begin
          if (sat) begin
            ovf_d   = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_next;
            if (fall) begin
              hi_latch_d = timer_next;
              state_d    = MEASURE_LOW;
            end
          end
        end
        MEASURE_LOW: begin
          if (sat) begin
            ovf_d   = 1'b1;
            state_d = IDLE;
          end else if (rise) begin
            // Closing edge doubles as the start of the next measurement.
            period_d  = timer_next;
            high_d    = hi_latch_q;
            valid_d   = 1'b1;
            start_clr = 1'b1;
            state_d   = MEASURE_HIGH;
          end else begin
            timer_d = timer_next;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start_clr) timer_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '1;
      prev_q     <= 1'b1;
      timer_q    <= '0;
      hi_latch_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      timer_q    <= timer_d;
      hi_latch_q <= hi_latch_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture: three instances (DIV=0, DIV=2, WIDTH=4)
// driven by hand-timed square waves; expected values computed by hand.
module tb_input_capture;

  logic clk = 1'b0;
  logic rst, en, clr, sig_a, sig_w;

  logic [15:0] per0, hi0, perd, hid;
  logic [3:0]  perw, hiw;
  logic        v0, vd, vw, ovf0, ovfd, ovfw, busy0, busyd, busyw;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  int q0_cyc[$], qd_cyc[$];
  int q0_per[$], q0_hi[$], qd_per[$], qd_hi[$];
  int vw_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_capture #(.WIDTH(16), .DIV(0), .SYNC_STAGES(2)) u_dut0 (
    .clk(clk), .rst(rst), .enable(en), .signal_in(sig_a), .clear_overflow(clr),
    .period(per0), .high_time(hi0), .valid(v0), .overflow(ovf0), .busy(busy0));

  input_capture #(.WIDTH(16), .DIV(2), .SYNC_STAGES(2)) u_div (
    .clk(clk), .rst(rst), .enable(en), .signal_in(sig_a), .clear_overflow(clr),
    .period(perd), .high_time(hid), .valid(vd), .overflow(ovfd), .busy(busyd));

  input_capture #(.WIDTH(4), .DIV(0), .SYNC_STAGES(2)) u_w4 (
    .clk(clk), .rst(rst), .enable(en), .signal_in(sig_w), .clear_overflow(clr),
    .period(perw), .high_time(hiw), .valid(vw), .overflow(ovfw), .busy(busyw));

  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      q0_cyc.push_back(cyc); q0_per.push_back(int'(per0)); q0_hi.push_back(int'(hi0));
    end
    if (vd === 1'b1) begin
      qd_cyc.push_back(cyc); qd_per.push_back(int'(perd)); qd_hi.push_back(int'(hid));
    end
    if (vw === 1'b1) vw_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int r0, s1, obs;
  int exp_cyc[4];

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; sig_a = 1'b1; sig_w = 1'b1;
    step(3);
    chk("rst_period", int'(per0), 0);
    chk("rst_high", int'(hi0), 0);
    chk("rst_valid", int'(v0), 0);
    chk("rst_overflow", int'(ovf0), 0);
    chk("rst_busy", int'(busy0), 0);

    // Held high through reset: no false start, nothing happens.
    rst = 1'b0; en = 1'b1;
    step(20);
    chk("idle_no_valid", q0_cyc.size(), 0);
    chk("idle_busy", int'(busy0), 0);
    chk("idle_overflow", int'(ovf0), 0);

    sig_a = 1'b0;
    step(30);
    r0 = cyc;
    for (int i = 0; i < 3; i++) begin
      sig_a = 1'b1; step(10);
      sig_a = 1'b0; step(30);
    end
    sig_a = 1'b1; step(10);
    sig_a = 1'b0; step(10);
    chk("pre_drop_busy", int'(busy0), 1);
    en = 1'b0;
    step(1);
    chk("drop_busy0", int'(busy0), 0);
    chk("drop_busyd", int'(busyd), 0);
    en = 1'b1;
    step(19);
    sig_a = 1'b1; step(10);
    sig_a = 1'b0; step(30);
    sig_a = 1'b1; step(10);
    sig_a = 1'b0; step(10);
    chk("pre_rst_busy", int'(busy0), 1);

    rst = 1'b1;
    step(1);
    chk("mrst_period", int'(per0), 0);
    chk("mrst_high", int'(hi0), 0);
    chk("mrst_valid", int'(v0), 0);
    chk("mrst_busy", int'(busy0), 0);
    chk("mrst_overflow", int'(ovf0), 0);
    rst = 1'b0;

    // WIDTH=4: start edge, then low long enough to saturate the timer.
    sig_w = 1'b0; step(5);
    s1 = cyc;
    sig_w = 1'b1; step(1);
    sig_w = 1'b0; step(17);
    chk("w4_ovf_before", int'(ovfw), 0);
    chk("w4_busy_before", int'(busyw), 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("w4_ovf_set_wins", int'(ovfw), 1);
    chk("w4_idle_after_ovf", int'(busyw), 0);
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("w4_ovf_cleared", int'(ovfw), 0);
    chk("w4_no_valid", vw_cnt, 0);
    chk("w4_period_hold", int'(perw), 0);
    chk("w4_step_base", cyc - s1, 21);

    // Valids: 3 back-to-back, the discarded partial, then one after restart.
    exp_cyc[0] = r0 + 43;
    exp_cyc[1] = r0 + 83;
    exp_cyc[2] = r0 + 123;
    exp_cyc[3] = r0 + 203;
    chk("dut0_valid_count", q0_cyc.size(), 4);
    chk("div_valid_count", qd_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      obs = (i < q0_cyc.size()) ? q0_cyc[i] : -1;
      chk($sformatf("dut0_valid_cyc%0d", i), obs, exp_cyc[i]);
      obs = (i < q0_per.size()) ? q0_per[i] : -1;
      chk($sformatf("dut0_period%0d", i), obs, 40);
      obs = (i < q0_hi.size()) ? q0_hi[i] : -1;
      chk($sformatf("dut0_high%0d", i), obs, 10);
      obs = (i < qd_cyc.size()) ? qd_cyc[i] : -1;
      chk($sformatf("div_valid_cyc%0d", i), obs, exp_cyc[i]);
      obs = (i < qd_per.size()) ? qd_per[i] : -1;
      chk($sformatf("div_period%0d", i), obs, 10);
      obs = (i < qd_hi.size()) ? qd_hi[i] : -1;
      chk($sformatf("div_high%0d", i), obs, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
